// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the legal operand-width range.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder built from two half-adder stages
// and an OR that merges their carries.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  // First half adder: x + y
  assign w_s1 = x ^ y;
  assign w_c1 = x & y;

  // Second half adder: partial sum + carry in
  assign s    = w_s1 ^ cin;
  assign w_c2 = w_s1 & cin;

  assign co   = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: latches two WIDTH-bit operands and adds them LSB-first,
// one bit per clock, through a single full-adder cell with a registered carry.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN, which
// adds the 'sub' input port.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end

  state_t             r_state;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_bit;
  logic               w_co;

  fa_cell u_fa (
    .x   (r_a_sh[0]),
    .y   (r_b_sh[0]),
    .cin (r_carry),
    .s   (w_bit),
    .co  (w_co)
  );

  // Control FSM and datapath. Result bits are shifted into the top of the
  // A shift register as A's bits are consumed from the bottom, so no separate
  // accumulator is needed: after WIDTH shifts it holds the full sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh  <= a;
`ifdef SERIAL_ADDER_SUB_EN
            r_b_sh  <= sub ? ~b : b;
            r_carry <= sub;
`else
            r_b_sh  <= b;
            r_carry <= 1'b0;
`endif
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          r_a_sh  <= {w_bit, r_a_sh[WIDTH-1:1]};
          r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_sum   <= {w_bit, r_a_sh[WIDTH-1:1]};
            r_cout  <= w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
